// File: rtl/mem_reset_sequencer.sv
// Reset sequencer for the DDR subsystem: pulses sys_reset, waits for mem_ok
// with timeout and bounded retry, then releases peripheral and CPU resets.
module mem_reset_sequencer #(
  parameter int PULSE_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int MAX_RETRIES    = 3,
  parameter int STAGE_DELAY    = 32
) (
  input  logic       clock,
  input  logic       aresetn,
  input  logic       mem_ok,
  input  logic       reset_request,
  output logic       sys_reset,
  output logic       periph_resetn,
  output logic       cpu_resetn,
  output logic       seq_busy,
  output logic       seq_fail,
  output logic [3:0] retry_count
);

  localparam int MAX_AB = (PULSE_CYCLES > TIMEOUT_CYCLES) ?
                          PULSE_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_C  = (MAX_AB > STAGE_DELAY) ? MAX_AB : STAGE_DELAY;
  localparam int CW     = $clog2(MAX_C) + 1;

  localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] D_LAST = CW'(STAGE_DELAY - 1);
  localparam logic [3:0]    R_MAX  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PULSE,
    S_WAIT,
    S_STAGE,
    S_RUN,
    S_FAIL
  } state_e;

  (* ASYNC_REG = "TRUE" *) logic [2:0] ok_sync_q;
  (* ASYNC_REG = "TRUE" *) logic [2:0] req_sync_q;
  logic req_dly_q;
  logic mem_ok_s;
  logic req_rise;

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      ok_sync_q  <= '0;
      req_sync_q <= '0;
      req_dly_q  <= 1'b0;
    end else begin
      ok_sync_q  <= {ok_sync_q[1:0], mem_ok};
      req_sync_q <= {req_sync_q[1:0], reset_request};
      req_dly_q  <= req_sync_q[2];
    end
  end

  assign mem_ok_s = ok_sync_q[2];
  assign req_rise = req_sync_q[2] & ~req_dly_q;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic          sys_q, sys_d;
  logic          per_q, per_d;
  logic          cpu_q, cpu_d;
  logic          busy_q, busy_d;
  logic          fail_q, fail_d;
  logic          restart;
  logic          fail_evt;

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_PULSE;
      cnt_q   <= '0;
      retry_q <= '0;
      sys_q   <= 1'b1;
      per_q   <= 1'b0;
      cpu_q   <= 1'b0;
      busy_q  <= 1'b1;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      sys_q   <= sys_d;
      per_q   <= per_d;
      cpu_q   <= cpu_d;
      busy_q  <= busy_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    fail_evt = 1'b0;
    // a fresh PULSE is already a restart; avoid re-arming it
    restart  = req_rise &&
               !(state_q == S_PULSE && cnt_q == '0);
    if (restart) begin
      state_d = S_PULSE;
      retry_d = '0;
    end else begin
      unique case (state_q)
        S_PULSE: begin
          if (cnt_q == P_LAST) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (mem_ok_s) state_d = S_STAGE;
          else if (cnt_q == T_LAST) fail_evt = 1'b1;
        end
        S_STAGE: begin
          if (!mem_ok_s) begin
            fail_evt = 1'b1;
          end else if (cnt_q == D_LAST) begin
            state_d = S_RUN;
            retry_d = '0;
          end
        end
        S_RUN: begin
          if (!mem_ok_s) state_d = S_PULSE;
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: state_d = S_PULSE;
      endcase
      if (fail_evt) begin
        if (retry_q < R_MAX) begin
          retry_d = retry_q + 4'd1;
          state_d = S_PULSE;
        end else begin
          state_d = S_FAIL;
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (restart || state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q inside {S_PULSE, S_WAIT, S_STAGE}) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    sys_d  = state_d inside {S_PULSE, S_FAIL};
    per_d  = state_d inside {S_STAGE, S_RUN};
    cpu_d  = (state_d == S_RUN);
    busy_d = state_d inside {S_PULSE, S_WAIT, S_STAGE};
    fail_d = (state_d == S_FAIL);
  end

  assign sys_reset     = sys_q;
  assign periph_resetn = per_q;
  assign cpu_resetn    = cpu_q;
  assign seq_busy      = busy_q;
  assign seq_fail      = fail_q;
  assign retry_count   = retry_q;

endmodule
